// File: rtl/operand_fetch_unit.sv
// Operand fetch stage: reads the register file, bypasses same-cycle writeback,
// stalls RAW/WAW hazards via a busy-bit scoreboard, and registers operands for execute.
module operand_fetch_unit #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic              req_rd_we,
  output logic [ADDR_W-1:0] rf_rd_addr1,
  output logic [ADDR_W-1:0] rf_rd_addr2,
  input  logic [WIDTH-1:0]  rf_rd_data1,
  input  logic [WIDTH-1:0]  rf_rd_data2,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [WIDTH-1:0]  rf_wr_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [WIDTH-1:0]  op_rs1_data,
  output logic [WIDTH-1:0]  op_rs2_data,
  output logic [ADDR_W-1:0] op_rd,
  output logic              op_rd_we
);

  function automatic logic wb_hit(input logic              vld,
                                  input logic [ADDR_W-1:0] waddr,
                                  input logic [ADDR_W-1:0] rs);
    return vld && (waddr == rs) && (rs != '0);
  endfunction

  function automatic logic [WIDTH-1:0] sel_operand(input logic [ADDR_W-1:0] rs,
                                                   input logic              hit,
                                                   input logic [WIDTH-1:0]  wdata,
                                                   input logic [WIDTH-1:0]  rdata);
    if (rs == '0) return '0;
    else if (hit) return wdata;
    else return rdata;
  endfunction

  logic              vld_p1;
  logic [WIDTH-1:0]  rs1_data_p1, rs2_data_p1;
  logic [ADDR_W-1:0] rd_p1;
  logic              rd_we_p1;
  logic [DEPTH-1:0]  sb_busy, sb_busy_nxt;

  logic             hit1, hit2, raw1, raw2, waw, hazard, accept;
  logic [WIDTH-1:0] opnd1_p0, opnd2_p0;

  assign rf_rd_addr1 = req_rs1;
  assign rf_rd_addr2 = req_rs2;
  assign rf_wr_en    = wb_valid && (wb_addr != '0);
  assign rf_wr_addr  = wb_addr;
  assign rf_wr_data  = wb_data;

  // Stage p0: bypass, hazard detection and handshake
  always_comb begin
    hit1     = wb_hit(wb_valid, wb_addr, req_rs1);
    hit2     = wb_hit(wb_valid, wb_addr, req_rs2);
    opnd1_p0 = sel_operand(req_rs1, hit1, wb_data, rf_rd_data1);
    opnd2_p0 = sel_operand(req_rs2, hit2, wb_data, rf_rd_data2);
    raw1     = (req_rs1 != '0) && sb_busy[req_rs1] && !hit1;
    raw2     = (req_rs2 != '0) && sb_busy[req_rs2] && !hit2;
    // A writeback retiring the old producer lets the new one issue this cycle.
    waw      = req_rd_we && (req_rd != '0) && sb_busy[req_rd]
               && !(wb_valid && (wb_addr == req_rd));
    hazard   = raw1 || raw2 || waw;
    req_ready = (!vld_p1 || op_ready) && !hazard;
    accept   = req_valid && req_ready;
  end

  always_comb begin
    sb_busy_nxt = sb_busy;
    if (wb_valid) sb_busy_nxt[wb_addr] = 1'b0;
    if (accept && req_rd_we && (req_rd != '0)) sb_busy_nxt[req_rd] = 1'b1;
    sb_busy_nxt[0] = 1'b0;
  end

  // Stage p1: registered operands toward execute
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      rd_p1       <= '0;
      rd_we_p1    <= 1'b0;
      sb_busy     <= '0;
    end else begin
      sb_busy <= sb_busy_nxt;
      if (accept) begin
        vld_p1      <= 1'b1;
        rs1_data_p1 <= opnd1_p0;
        rs2_data_p1 <= opnd2_p0;
        rd_p1       <= req_rd;
        rd_we_p1    <= req_rd_we;
      end else if (op_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign op_valid    = vld_p1;
  assign op_rs1_data = rs1_data_p1;
  assign op_rs2_data = rs2_data_p1;
  assign op_rd       = rd_p1;
  assign op_rd_we    = rd_we_p1;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit with a small behavioural register file.
module tb_operand_fetch_unit;
  localparam int WIDTH = 32, DEPTH = 32, ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic              req_valid, req_ready, req_rd_we;
  logic [ADDR_W-1:0] req_rs1, req_rs2, req_rd;
  logic [ADDR_W-1:0] rf_rd_addr1, rf_rd_addr2;
  logic [WIDTH-1:0]  rf_rd_data1, rf_rd_data2;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [WIDTH-1:0]  wb_data;
  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [WIDTH-1:0]  rf_wr_data;
  logic              op_valid, op_ready, op_rd_we;
  logic [WIDTH-1:0]  op_rs1_data, op_rs2_data;
  logic [ADDR_W-1:0] op_rd;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] rf [DEPTH];

  operand_fetch_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_rd_we(req_rd_we),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data),
    .op_rd(op_rd), .op_rd_we(op_rd_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model; entry 0 deliberately holds garbage to prove the unit zeroes it.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      rf[0] <= 32'hDEAD_BEEF;
      rf[3] <= 32'h33;
      rf[5] <= 32'h11;
      rf[6] <= 32'h22;
    end else if (rf_wr_en) begin
      rf[rf_wr_addr] <= rf_wr_data;
    end
  end
  assign rf_rd_data1 = rf[rf_rd_addr1];
  assign rf_rd_data2 = rf[rf_rd_addr2];

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                         input logic [ADDR_W-1:0] rd, input logic we);
    req_valid = 1'b1;
    req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_rd_we = we;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_rd_we = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0; op_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_op_valid", {31'b0, op_valid}, 32'h0);
    chk("rst_rs1_data", op_rs1_data, 32'h0);
    chk("rst_op_rd", {27'b0, op_rd}, 32'h0);
    chk("rst_busy", dut.sb_busy, 32'h0);

    // Basic issue from the register file
    set_req(5, 6, 7, 1'b1);
    #1;
    chk("issue_ready", {31'b0, req_ready}, 32'h1);
    chk("rd_addr1", {27'b0, rf_rd_addr1}, 32'd5);
    tick();
    chk("issue_valid", {31'b0, op_valid}, 32'h1);
    chk("issue_rs1", op_rs1_data, 32'h11);
    chk("issue_rs2", op_rs2_data, 32'h22);
    chk("issue_rd", {27'b0, op_rd}, 32'd7);
    chk("issue_rd_we", {31'b0, op_rd_we}, 32'h1);
    chk("busy7_set", {31'b0, dut.sb_busy[7]}, 32'h1);

    // RAW on x7, resolved by same-cycle writeback bypass
    set_req(7, 0, 8, 1'b1);
    #1;
    chk("raw_stall", {31'b0, req_ready}, 32'h0);
    wb_valid = 1'b1; wb_addr = 7; wb_data = 32'hABCD;
    #1;
    chk("raw_bypass_ready", {31'b0, req_ready}, 32'h1);
    chk("wb_wr_en", {31'b0, rf_wr_en}, 32'h1);
    tick();
    wb_valid = 1'b0;
    chk("bypass_rs1", op_rs1_data, 32'hABCD);
    chk("bypass_rs2_x0", op_rs2_data, 32'h0);
    chk("bypass_rd", {27'b0, op_rd}, 32'd8);
    chk("busy7_clr", {31'b0, dut.sb_busy[7]}, 32'h0);
    chk("busy8_set", {31'b0, dut.sb_busy[8]}, 32'h1);
    chk("rf7_written", rf[7], 32'hABCD);

    // x0 reads as zero and is never written or marked busy
    set_req(0, 0, 0, 1'b1);
    wb_valid = 1'b1; wb_addr = 0; wb_data = 32'h1234;
    #1;
    chk("x0_wr_en", {31'b0, rf_wr_en}, 32'h0);
    chk("x0_ready", {31'b0, req_ready}, 32'h1);
    tick();
    wb_valid = 1'b0;
    chk("x0_valid", {31'b0, op_valid}, 32'h1);
    chk("x0_rs1", op_rs1_data, 32'h0);
    chk("x0_rs2", op_rs2_data, 32'h0);
    chk("x0_busy", {31'b0, dut.sb_busy[0]}, 32'h0);
    chk("x0_rf_untouched", rf[0], 32'hDEAD_BEEF);

    // Hold while execute back-pressures; unrelated writeback must not disturb
    set_req(5, 6, 10, 1'b0);
    tick();
    chk("hold_cap_rd", {27'b0, op_rd}, 32'd10);
    op_ready = 1'b0;
    set_req(6, 5, 11, 1'b1);
    wb_valid = 1'b1; wb_addr = 8; wb_data = 32'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready", {31'b0, req_ready}, 32'h0);
      tick();
      chk("hold_valid", {31'b0, op_valid}, 32'h1);
      chk("hold_rs1", op_rs1_data, 32'h11);
      chk("hold_rs2", op_rs2_data, 32'h22);
      chk("hold_rd", {27'b0, op_rd}, 32'd10);
    end
    wb_valid = 1'b0;
    op_ready = 1'b1;
    #1;
    chk("release_ready", {31'b0, req_ready}, 32'h1);
    tick();
    chk("release_rs1", op_rs1_data, 32'h22);
    chk("release_rs2", op_rs2_data, 32'h11);
    chk("release_rd", {27'b0, op_rd}, 32'd11);
    chk("busy8_clr", {31'b0, dut.sb_busy[8]}, 32'h0);

    // WAW on x9: stall, then release by writeback with set-wins
    set_req(0, 0, 9, 1'b1);
    tick();
    chk("waw_first_busy", {31'b0, dut.sb_busy[9]}, 32'h1);
    set_req(5, 0, 9, 1'b1);
    #1;
    chk("waw_stall", {31'b0, req_ready}, 32'h0);
    tick();
    chk("drain_valid", {31'b0, op_valid}, 32'h0);
    chk("drain_keep_rd", {27'b0, op_rd}, 32'd9);
    wb_valid = 1'b1; wb_addr = 9; wb_data = 32'h77;
    #1;
    chk("waw_release", {31'b0, req_ready}, 32'h1);
    tick();
    wb_valid = 1'b0;
    chk("waw_valid", {31'b0, op_valid}, 32'h1);
    chk("waw_rs1", op_rs1_data, 32'h11);
    chk("waw_set_wins", {31'b0, dut.sb_busy[9]}, 32'h1);

    // Reset while holding with x3 busy
    set_req(0, 0, 3, 1'b1);
    tick();
    chk("busy3_set", {31'b0, dut.sb_busy[3]}, 32'h1);
    op_ready = 1'b0;
    set_req(3, 0, 0, 1'b0);
    #1;
    chk("pre_rst_stall", {31'b0, req_ready}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", {31'b0, op_valid}, 32'h0);
    chk("mid_rst_rs1", op_rs1_data, 32'h0);
    chk("mid_rst_rd", {27'b0, op_rd}, 32'h0);
    chk("mid_rst_busy", dut.sb_busy, 32'h0);
    chk("post_rst_ready", {31'b0, req_ready}, 32'h1);
    tick();
    req_valid = 1'b0;
    chk("post_rst_valid", {31'b0, op_valid}, 32'h1);
    chk("post_rst_rs1", op_rs1_data, 32'h33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_fetch_unit.md
Name: operand_fetch_unit

Overview:
- Read-side client of the core register file; sits between decode and execute.
- Accepts decoded instructions over valid/ready and drives the register file's two asynchronous read ports.
- Forwards same-cycle writeback data and tracks in-flight destinations in a scoreboard to stall RAW/WAW hazards.
- Presents registered operands to execute over valid/ready; also drives the register file write port from the writeback bus.

Parameters:
WIDTH, 32, data width of each register
DEPTH, 32, number of architectural registers
ADDR_W, 5, register address width; DEPTH == 2**ADDR_W

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  decoded instruction available
req_ready  output  1  instruction accepted this cycle when req_valid && req_ready
req_rs1  input  ADDR_W  source register 1
req_rs2  input  ADDR_W  source register 2
req_rd  input  ADDR_W  destination register
req_rd_we  input  1  instruction will write req_rd
rf_rd_addr1  output  ADDR_W  register file read address 1 (= req_rs1, combinational)
rf_rd_addr2  output  ADDR_W  register file read address 2 (= req_rs2, combinational)
rf_rd_data1  input  WIDTH  register file asynchronous read data 1
rf_rd_data2  input  WIDTH  register file asynchronous read data 2
wb_valid  input  1  writeback of wb_data to wb_addr this cycle
wb_addr  input  ADDR_W  writeback destination
wb_data  input  WIDTH  writeback value
rf_wr_en  output  1  register file write enable = wb_valid && wb_addr != 0
rf_wr_addr  output  ADDR_W  = wb_addr
rf_wr_data  output  WIDTH  = wb_data
op_valid  output  1  operands valid toward execute
op_ready  input  1  execute accepts operands
op_rs1_data  output  WIDTH  operand 1
op_rs2_data  output  WIDTH  operand 2
op_rd  output  ADDR_W  destination register, passed through
op_rd_we  output  1  destination write enable, passed through

Behaviour:
- Reset: op_valid=0; op_rs1_data, op_rs2_data, op_rd, op_rd_we = 0; all scoreboard busy bits cleared. Reset mid-stall or mid-hold discards the held operands and all pending state. Writebacks arriving after reset do not re-set busy bits.
- Register 0 reads as zero, is never marked busy, and is never written (rf_wr_en masked).
- Same-cycle bypass: wb_hit(rs) = wb_valid && wb_addr == rs && rs != 0.
- Operand select: rs==0 -> 0; else wb_hit -> wb_data; else rf_rd_data.
- Hazard conditions:
  - RAW: rs1 != 0 && busy[rs1] && !wb_hit(rs1); same rule for rs2.
  - WAW: req_rd_we && req_rd != 0 && busy[rd] && !(wb_valid && wb_addr == rd).
- req_ready = (!op_valid || op_ready) && !hazard. req_ready is combinational and may depend on req_* fields.
- Accept (req_valid && req_ready): next cycle op_valid=1 with the selected operands and rd/rd_we captured. Latency is 1 cycle from accept to op_valid. Back-to-back accepts sustain 1 instruction/cycle.
- Hold: while op_valid && !op_ready, all op_* outputs stay stable. Later writebacks do not update held operands; the hazard check guaranteed they were current.
- Drain: op_valid && op_ready with no new accept -> op_valid=0; data outputs keep their last value.
- Scoreboard update, per cycle:
  - Clear busy[wb_addr] on wb_valid.
  - Set busy[req_rd] on accept with req_rd_we && req_rd != 0.
  - Same address cleared and set in the same cycle -> set wins (new producer).
- The WAW stall guarantees at most one outstanding producer per register. A writeback to a non-busy register is legal: the RF write still occurs, the clear is a no-op, no error.
- req_* must be held stable while req_valid && !req_ready; the unit does not check this.
- No internal FSM beyond the op_valid output stage and the DEPTH-bit scoreboard.

Test Plan:
- Reset, then RF preloaded x5=0x11, x6=0x22; issue rs1=5 rs2=6 rd=7 we=1 with op_ready=1 -> next cycle op_valid=1, data 0x11/0x22, op_rd=7; busy[7]=1.
- Issue rd=7, then rs1=7 -> req_ready=0 while busy[7]. Assert wb_valid wb_addr=7 wb_data=0xABCD the same cycle as the retry -> accepted that cycle, op_rs1_data=0xABCD, busy[7]=0.
- rs1=0 rs2=0 with RF entry 0 forced nonzero -> operands 0. wb to addr 0 -> rf_wr_en=0, busy[0] stays 0.
- op_ready=0 for 3 cycles after accept, with wb to an unrelated register -> op_* stable, req_ready=0. op_ready=1 -> next instruction accepted same cycle, no bubble.
- WAW: rd=9 outstanding, new request rd=9 -> stalls. wb addr 9 arrives -> new request accepted same cycle, busy[9] remains 1 (set wins).
- Assert rst while op_valid=1, op_ready=0, busy[3]=1 -> next cycle op_valid=0, all busy clear, request reading x3 accepted immediately.
